// File: rtl/cache_ctrl_2way.sv
// Miss/refill sequencer for a two-way set-associative cache.
// Holds the tag/valid/dirty state, performs the lookup, drives the
// external MRU replacement block and sequences dirty writeback plus
// line refill over a single-outstanding memory request port.
module cache_ctrl_2way #(
    parameter int SETS       = 128,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int OFF_W      = $clog2(LINE_BYTES),
    parameter int IDX_W      = $clog2(SETS),
    parameter int TAG_W      = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    output logic              rsp_valid_o,
    output logic              rsp_hit_o,
    output logic              rsp_way_o,
    output logic [IDX_W-1:0]  repl_set_index_o,
    output logic              repl_way0_valid_o,
    output logic              repl_way1_valid_o,
    output logic              repl_hit_o,
    output logic              repl_way_hit_o,
    output logic              repl_miss_o,
    output logic              repl_fill_o,
    output logic              repl_way_filled_o,
    input  logic              repl_victim_i,
    output logic              data_fill_o,
    output logic              data_way_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        RF_REQ,
        RF_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    // Low during reset and until the first clock edge after release,
    // so every output stays at zero across that window.
    logic active;

    logic [TAG_W-1:0] tag_lat;
    logic [IDX_W-1:0] index_lat;
    logic             we_lat;
    logic             victim_lat;

    logic [SETS-1:0]  valid0;
    logic [SETS-1:0]  valid1;
    logic [SETS-1:0]  dirty0;
    logic [SETS-1:0]  dirty1;
    logic [TAG_W-1:0] tag0_arr [SETS];
    logic [TAG_W-1:0] tag1_arr [SETS];

    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             hit0;
    logic             hit1;
    logic             hit_any;
    logic             hit_way;
    logic             victim_dirty;
    logic [TAG_W-1:0] wb_tag;
    logic             refill_done;

    // The controller works on whole lines; the byte offset is not needed.
    logic unused_off;
    assign unused_off = ^req_addr_i[OFF_W-1:0];

    assign req_index    = req_addr_i[OFF_W +: IDX_W];
    assign req_tag      = req_addr_i[ADDR_W-1 -: TAG_W];
    assign hit0         = valid0[index_lat] && (tag0_arr[index_lat] == tag_lat);
    assign hit1         = valid1[index_lat] && (tag1_arr[index_lat] == tag_lat);
    assign hit_any      = hit0 || hit1;
    assign hit_way      = !hit0;
    assign victim_dirty = repl_victim_i ? (valid1[index_lat] && dirty1[index_lat])
                                        : (valid0[index_lat] && dirty0[index_lat]);
    assign wb_tag       = victim_lat ? tag1_arr[index_lat] : tag0_arr[index_lat];
    assign refill_done  = (state == RF_WAIT) && mem_rsp_valid_i;

    assign repl_way0_valid_o = valid0[repl_set_index_o];
    assign repl_way1_valid_o = valid1[repl_set_index_o];

    // Next-state decode and all strobes/handshake outputs for the current state.
    always_comb begin
        state_next        = state;
        req_ready_o       = 1'b0;
        rsp_valid_o       = 1'b0;
        rsp_hit_o         = 1'b0;
        rsp_way_o         = 1'b0;
        repl_set_index_o  = index_lat;
        repl_hit_o        = 1'b0;
        repl_way_hit_o    = 1'b0;
        repl_miss_o       = 1'b0;
        repl_fill_o       = 1'b0;
        repl_way_filled_o = 1'b0;
        data_fill_o       = 1'b0;
        data_way_o        = 1'b0;
        mem_req_valid_o   = 1'b0;
        mem_req_we_o      = 1'b0;
        mem_req_addr_o    = '0;
        case (state)
            IDLE: begin
                repl_set_index_o = active ? req_index : '0;
                req_ready_o      = active;
                if (active && req_valid_i) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_any) begin
                    repl_hit_o     = 1'b1;
                    repl_way_hit_o = hit_way;
                    rsp_valid_o    = 1'b1;
                    rsp_hit_o      = 1'b1;
                    rsp_way_o      = hit_way;
                    state_next     = IDLE;
                end else begin
                    repl_miss_o = 1'b1;
                    state_next  = victim_dirty ? WB_REQ : RF_REQ;
                end
            end
            WB_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = {wb_tag, index_lat, {OFF_W{1'b0}}};
                if (mem_req_ready_i) begin
                    state_next = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_next = RF_REQ;
                end
            end
            RF_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {tag_lat, index_lat, {OFF_W{1'b0}}};
                if (mem_req_ready_i) begin
                    state_next = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (mem_rsp_valid_i) begin
                    data_fill_o       = 1'b1;
                    data_way_o        = victim_lat;
                    repl_fill_o       = 1'b1;
                    repl_way_filled_o = victim_lat;
                    rsp_valid_o       = 1'b1;
                    rsp_way_o         = victim_lat;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, request latches and the valid/dirty bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            active     <= 1'b0;
            tag_lat    <= '0;
            index_lat  <= '0;
            we_lat     <= 1'b0;
            victim_lat <= 1'b0;
            valid0     <= '0;
            valid1     <= '0;
            dirty0     <= '0;
            dirty1     <= '0;
        end else begin
            active <= 1'b1;
            state  <= state_next;
            if (state == IDLE && active && req_valid_i) begin
                tag_lat   <= req_tag;
                index_lat <= req_index;
                we_lat    <= req_we_i;
            end
            if (state == LOOKUP && !hit_any) begin
                victim_lat <= repl_victim_i;
            end
            if (state == LOOKUP && hit_any && we_lat) begin
                if (hit_way) begin
                    dirty1[index_lat] <= 1'b1;
                end else begin
                    dirty0[index_lat] <= 1'b1;
                end
            end
            if (refill_done) begin
                if (victim_lat) begin
                    valid1[index_lat] <= 1'b1;
                    dirty1[index_lat] <= we_lat;
                end else begin
                    valid0[index_lat] <= 1'b1;
                    dirty0[index_lat] <= we_lat;
                end
            end
        end
    end

    // Tag storage is only meaningful where the valid bit is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            if (victim_lat) begin
                tag1_arr[index_lat] <= tag_lat;
            end else begin
                tag0_arr[index_lat] <= tag_lat;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed testbench for cache_ctrl_2way: the bench plays the core, the
// replacement block and the memory side, one scenario task per feature.
module tb_cache_ctrl_2way;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 7;

    // Output bundle ordering:
    // req_ready _ rsp_valid rsp_hit rsp_way _ repl_hit repl_way_hit repl_miss
    // _ repl_fill repl_way_filled _ data_fill data_way _ mem_req_valid mem_req_we
    localparam logic [12:0] V_NONE  = 13'b0_000_000_00_00_00;
    localparam logic [12:0] V_IDLE  = 13'b1_000_000_00_00_00;
    localparam logic [12:0] V_MISS  = 13'b0_000_001_00_00_00;
    localparam logic [12:0] V_HIT0  = 13'b0_110_100_00_00_00;
    localparam logic [12:0] V_RFREQ = 13'b0_000_000_00_00_10;
    localparam logic [12:0] V_WBREQ = 13'b0_000_000_00_00_11;
    localparam logic [12:0] V_FILL0 = 13'b0_100_000_10_10_00;
    localparam logic [12:0] V_FILL1 = 13'b0_101_000_11_11_00;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_we_i;
    logic              rsp_valid_o;
    logic              rsp_hit_o;
    logic              rsp_way_o;
    logic [IDX_W-1:0]  repl_set_index_o;
    logic              repl_way0_valid_o;
    logic              repl_way1_valid_o;
    logic              repl_hit_o;
    logic              repl_way_hit_o;
    logic              repl_miss_o;
    logic              repl_fill_o;
    logic              repl_way_filled_o;
    logic              repl_victim_i;
    logic              data_fill_o;
    logic              data_way_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic              mem_req_we_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic              mem_rsp_valid_i;

    int errors = 0;
    int checks = 0;

    logic [12:0] obs;
    logic [8:0]  set_obs;

    assign obs = {req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o,
                  repl_hit_o, repl_way_hit_o, repl_miss_o,
                  repl_fill_o, repl_way_filled_o,
                  data_fill_o, data_way_o,
                  mem_req_valid_o, mem_req_we_o};
    assign set_obs = {repl_set_index_o, repl_way0_valid_o, repl_way1_valid_o};

    always #5 clk_i = ~clk_i;

    cache_ctrl_2way dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_we_i          (req_we_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_hit_o         (rsp_hit_o),
        .rsp_way_o         (rsp_way_o),
        .repl_set_index_o  (repl_set_index_o),
        .repl_way0_valid_o (repl_way0_valid_o),
        .repl_way1_valid_o (repl_way1_valid_o),
        .repl_hit_o        (repl_hit_o),
        .repl_way_hit_o    (repl_way_hit_o),
        .repl_miss_o       (repl_miss_o),
        .repl_fill_o       (repl_fill_o),
        .repl_way_filled_o (repl_way_filled_o),
        .repl_victim_i     (repl_victim_i),
        .data_fill_o       (data_fill_o),
        .data_way_o        (data_way_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_req_we_o      (mem_req_we_o),
        .mem_req_addr_o    (mem_req_addr_o),
        .mem_rsp_valid_i   (mem_rsp_valid_i)
    );

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_valid_i = 1'b1; req_addr_i = 32'h0000_1040; req_we_i = 1'b0;
        repl_victim_i = 1'b0; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b1;
        step(); #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL rst_outputs obs=%b exp=%b", obs, V_NONE); end
        checks++; if (set_obs !== 9'd0) begin errors++; $display("[TB] FAIL rst_set obs=%h exp=0", set_obs); end
        checks++; if (mem_req_addr_o !== 32'd0) begin errors++; $display("[TB] FAIL rst_addr got=%h exp=0", mem_req_addr_o); end
        step(); rst_ni = 1'b1; req_valid_i = 1'b0; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL rst_release_ready obs=%b exp=%b", obs, V_NONE); end
        step(); #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL rst_first_edge obs=%b exp=%b", obs, V_IDLE); end
        checks++; if (set_obs !== {7'd2, 2'b00}) begin errors++; $display("[TB] FAIL rst_idle_set obs=%h exp=%h", set_obs, {7'd2, 2'b00}); end
    endtask

    task automatic test_cold_miss();
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_1040; req_we_i = 1'b0; repl_victim_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL cold_accept obs=%b exp=%b", obs, V_IDLE); end
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_MISS) begin errors++; $display("[TB] FAIL cold_lookup obs=%b exp=%b", obs, V_MISS); end
        checks++; if (set_obs !== {7'd2, 2'b00}) begin errors++; $display("[TB] FAIL cold_set obs=%h exp=%h", set_obs, {7'd2, 2'b00}); end
        step(); mem_req_ready_i = 1'b1; #1;
        checks++; if (obs !== V_RFREQ) begin errors++; $display("[TB] FAIL cold_rfreq obs=%b exp=%b", obs, V_RFREQ); end
        checks++; if (mem_req_addr_o !== 32'h0000_1040) begin errors++; $display("[TB] FAIL cold_rf_addr got=%h exp=00001040", mem_req_addr_o); end
        step(); mem_req_ready_i = 1'b0; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL cold_rfwait obs=%b exp=%b", obs, V_NONE); end
        step(); mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_FILL0) begin errors++; $display("[TB] FAIL cold_fill obs=%b exp=%b", obs, V_FILL0); end
        step(); mem_rsp_valid_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL cold_back_idle obs=%b exp=%b", obs, V_IDLE); end
        checks++; if (set_obs !== {7'd2, 2'b10}) begin errors++; $display("[TB] FAIL cold_valid0 obs=%h exp=%h", set_obs, {7'd2, 2'b10}); end
    endtask

    task automatic test_hit();
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_1040; req_we_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL hit_accept obs=%b exp=%b", obs, V_IDLE); end
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_HIT0) begin errors++; $display("[TB] FAIL hit_rsp obs=%b exp=%b", obs, V_HIT0); end
        step(); #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL hit_next_accept obs=%b exp=%b", obs, V_IDLE); end
    endtask

    task automatic test_second_way();
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_2040; repl_victim_i = 1'b1; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL way1_accept obs=%b exp=%b", obs, V_IDLE); end
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_MISS) begin errors++; $display("[TB] FAIL way1_lookup obs=%b exp=%b", obs, V_MISS); end
        step(); mem_req_ready_i = 1'b1; #1;
        checks++; if (mem_req_addr_o !== 32'h0000_2040) begin errors++; $display("[TB] FAIL way1_rf_addr got=%h exp=00002040", mem_req_addr_o); end
        step(); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_FILL1) begin errors++; $display("[TB] FAIL way1_fill obs=%b exp=%b", obs, V_FILL1); end
        step(); mem_rsp_valid_i = 1'b0; #1;
        checks++; if (set_obs !== {7'd2, 2'b11}) begin errors++; $display("[TB] FAIL way1_valids obs=%h exp=%h", set_obs, {7'd2, 2'b11}); end
    endtask

    task automatic test_writeback();
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_1040; req_we_i = 1'b1; #1;
        step(); req_valid_i = 1'b0; req_we_i = 1'b0; #1;
        checks++; if (obs !== V_HIT0) begin errors++; $display("[TB] FAIL wb_store_hit obs=%b exp=%b", obs, V_HIT0); end
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_3040; repl_victim_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL wb_accept obs=%b exp=%b", obs, V_IDLE); end
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_MISS) begin errors++; $display("[TB] FAIL wb_lookup obs=%b exp=%b", obs, V_MISS); end
        step(); repl_victim_i = 1'b1; #1;
        checks++; if (obs !== V_WBREQ) begin errors++; $display("[TB] FAIL wb_req obs=%b exp=%b", obs, V_WBREQ); end
        checks++; if (mem_req_addr_o !== 32'h0000_1040) begin errors++; $display("[TB] FAIL wb_addr got=%h exp=00001040", mem_req_addr_o); end
        step(); mem_req_ready_i = 1'b1; #1;
        checks++; if (obs !== V_WBREQ) begin errors++; $display("[TB] FAIL wb_req_hold obs=%b exp=%b", obs, V_WBREQ); end
        step(); mem_req_ready_i = 1'b0; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL wb_wait obs=%b exp=%b", obs, V_NONE); end
        step(); mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL wb_ack_no_rsp obs=%b exp=%b", obs, V_NONE); end
        step(); mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
        checks++; if (obs !== V_RFREQ) begin errors++; $display("[TB] FAIL wb_then_rf obs=%b exp=%b", obs, V_RFREQ); end
        checks++; if (mem_req_addr_o !== 32'h0000_3040) begin errors++; $display("[TB] FAIL wb_rf_addr got=%h exp=00003040", mem_req_addr_o); end
        step(); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_FILL0) begin errors++; $display("[TB] FAIL wb_fill_way0 obs=%b exp=%b", obs, V_FILL0); end
        step(); mem_rsp_valid_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL wb_back_idle obs=%b exp=%b", obs, V_IDLE); end
    endtask

    task automatic test_stall();
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_5040; repl_victim_i = 1'b1; #1;
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_MISS) begin errors++; $display("[TB] FAIL stall_lookup obs=%b exp=%b", obs, V_MISS); end
        for (int i = 0; i < 5; i++) begin
            step();
            repl_victim_i   = 1'b0;
            mem_req_ready_i = 1'b0;
            req_valid_i     = (i % 2 == 1);
            req_addr_i      = (i % 2 == 1) ? 32'h0000_7fe0 : 32'h0000_5040;
            mem_rsp_valid_i = (i == 2 || i == 3);
            #1;
            checks++; if (obs !== V_RFREQ) begin errors++; $display("[TB] FAIL stall_hold_%0d obs=%b exp=%b", i, obs, V_RFREQ); end
            checks++; if (mem_req_addr_o !== 32'h0000_5040) begin errors++; $display("[TB] FAIL stall_addr_%0d got=%h exp=00005040", i, mem_req_addr_o); end
            checks++; if (repl_set_index_o !== 7'd2) begin errors++; $display("[TB] FAIL stall_set_%0d got=%0d exp=2", i, repl_set_index_o); end
        end
        step(); req_valid_i = 1'b0; req_addr_i = 32'h0000_5040; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
        checks++; if (obs !== V_RFREQ) begin errors++; $display("[TB] FAIL stall_release obs=%b exp=%b", obs, V_RFREQ); end
        step(); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_FILL1) begin errors++; $display("[TB] FAIL stall_fill obs=%b exp=%b", obs, V_FILL1); end
        step(); mem_rsp_valid_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL stall_back_idle obs=%b exp=%b", obs, V_IDLE); end
    endtask

    task automatic test_reset_mid_miss();
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_1040; repl_victim_i = 1'b0; #1;
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_MISS) begin errors++; $display("[TB] FAIL mid_lookup obs=%b exp=%b", obs, V_MISS); end
        step(); mem_req_ready_i = 1'b1; #1;
        step(); mem_req_ready_i = 1'b0; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL mid_rfwait obs=%b exp=%b", obs, V_NONE); end
        step(); rst_ni = 1'b0; mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL mid_rst_outputs obs=%b exp=%b", obs, V_NONE); end
        checks++; if (set_obs !== 9'd0) begin errors++; $display("[TB] FAIL mid_rst_set obs=%h exp=0", set_obs); end
        step(); rst_ni = 1'b1; mem_rsp_valid_i = 1'b0; #1;
        checks++; if (obs !== V_NONE) begin errors++; $display("[TB] FAIL mid_release obs=%b exp=%b", obs, V_NONE); end
        step(); req_valid_i = 1'b1; req_addr_i = 32'h0000_1040; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL mid_idle obs=%b exp=%b", obs, V_IDLE); end
        checks++; if (set_obs !== {7'd2, 2'b00}) begin errors++; $display("[TB] FAIL mid_valids_cleared obs=%h exp=%h", set_obs, {7'd2, 2'b00}); end
        step(); req_valid_i = 1'b0; #1;
        checks++; if (obs !== V_MISS) begin errors++; $display("[TB] FAIL mid_re_miss obs=%b exp=%b", obs, V_MISS); end
        step(); mem_req_ready_i = 1'b1; #1;
        checks++; if (mem_req_addr_o !== 32'h0000_1040) begin errors++; $display("[TB] FAIL mid_rf_addr got=%h exp=00001040", mem_req_addr_o); end
        step(); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; #1;
        checks++; if (obs !== V_FILL0) begin errors++; $display("[TB] FAIL mid_fill obs=%b exp=%b", obs, V_FILL0); end
        step(); mem_rsp_valid_i = 1'b0; #1;
        checks++; if (obs !== V_IDLE) begin errors++; $display("[TB] FAIL mid_back_idle obs=%b exp=%b", obs, V_IDLE); end
    endtask

    // Scenario sequence; each task leaves the controller idle for the next.
    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_second_way();
        test_writeback();
        test_stall();
        test_reset_mid_miss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Miss/refill sequencer for the two-way set-associative cache.
- Owns the tag/valid/dirty arrays and performs lookup.
- Drives the MRU replacement block: hit/miss/fill strobes out, victim way back in.
- Sequences dirty-victim writeback and line refill over a single-outstanding memory request port. Sits between the core load/store port and the L2/bus adapter; data arrays are external and driven by the fill strobes.

Parameters:
SETS, 128, number of sets (power of two)
ADDR_W, 32, address width
LINE_BYTES, 32, line size in bytes (power of two); OFF_W=$clog2(LINE_BYTES), IDX_W=$clog2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
req_valid_i  in  1  core request valid
req_ready_o  out  1  controller can accept request
req_addr_i  in  ADDR_W  request byte address
req_we_i  in  1  request is a store (marks line dirty)
rsp_valid_o  out  1  one-cycle completion pulse
rsp_hit_o  out  1  completion was a hit
rsp_way_o  out  1  way holding the line
repl_set_index_o  out  IDX_W  set index to replacement block
repl_way0_valid_o  out  1  way 0 valid bit of indexed set
repl_way1_valid_o  out  1  way 1 valid bit of indexed set
repl_hit_o  out  1  hit strobe
repl_way_hit_o  out  1  way that hit
repl_miss_o  out  1  miss strobe (victim requested)
repl_fill_o  out  1  fill strobe
repl_way_filled_o  out  1  way filled
repl_victim_i  in  1  victim way from replacement block (combinational)
data_fill_o  out  1  write refill line into data array
data_way_o  out  1  data array way for fill
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_we_o  out  1  1=writeback, 0=refill read
mem_req_addr_o  out  ADDR_W  line-aligned address (offset bits zero)
mem_rsp_valid_i  in  1  writeback ack / refill data present

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset effects:
  - state=IDLE; all valid and dirty bits cleared.
  - Every output is 0 while rst_ni is low; req_ready_o rises on the first clk_i edge after release.
  - Reset mid-miss aborts the transaction: no rsp_valid_o, mem request dropped.
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch tag/index/we and go to LOOKUP.
  - req_ready_o=0 in every other state; req_valid_i is ignored there.
- LOOKUP (exactly one cycle):
  - hitN = validN && tagN==tag.
  - If both ways match, way 0 wins.
- LOOKUP, hit:
  - repl_hit_o=1, repl_way_hit_o=way.
  - rsp_valid_o=1, rsp_hit_o=1, rsp_way_o=way.
  - Set dirty if we; go to IDLE.
  - Hit latency: accept edge N, response asserted in cycle N+1, next accept possible at N+2.
- LOOKUP, miss:
  - repl_miss_o=1; latch victim=repl_victim_i.
  - If victim valid&&dirty go to WB_REQ, else RF_REQ.
- WB_REQ:
  - mem_req_valid_o=1, we=1, addr={victim tag,index,0}.
  - Hold all mem_req_* stable until mem_req_ready_i, then go to WB_WAIT.
- WB_WAIT: on mem_rsp_valid_i go to RF_REQ.
- RF_REQ:
  - mem_req_valid_o=1, we=0, addr={req tag,index,0}.
  - Handshake as in WB_REQ, then go to RF_WAIT.
- RF_WAIT, on mem_rsp_valid_i (same cycle):
  - data_fill_o=1, data_way_o=victim.
  - Write tag, valid=1, dirty=we.
  - repl_fill_o=1, repl_way_filled_o=victim.
  - rsp_valid_o=1, rsp_hit_o=0, rsp_way_o=victim; go to IDLE.
- mem_rsp_valid_i outside WB_WAIT/RF_WAIT is ignored; mem_req_ready_i is ignored when mem_req_valid_o=0.
- repl_set_index_o and repl_way*_valid_o:
  - Reflect the latched index from LOOKUP until return to IDLE.
  - In IDLE they reflect req_addr_i index.
- repl_hit_o and repl_fill_o are never high in the same cycle; each strobe lasts exactly one cycle.
- The replacement block handles empty-way preference; this block never overrides repl_victim_i.

Test Plan:
- Reset then read 0x0000_1040 with mem_req_ready_i=1 and rsp 2 cycles later -> mem read addr 0x0000_1040, fill way 0, rsp_hit_o=0, rsp_way_o=0, set 2 valid0=1.
- Repeat read 0x0000_1040 -> rsp_valid_o at N+1, rsp_hit_o=1, rsp_way_o=0, repl_hit_o=1, no mem request.
- Read 0x0000_2040 (same set 2, new tag) -> victim way 1 (empty), fill way 1, repl_way_filled_o=1.
- Store hit to 0x0000_1040, then miss 0x0000_3040 with repl_victim_i=0 -> WB addr 0x0000_1040 we=1, then refill 0x0000_3040 we=0, rsp_way_o=0.
- mem_req_ready_i held 0 for 5 cycles in RF_REQ -> mem_req_valid_o and mem_req_addr_o stable all 5 cycles; req_valid_i pulses ignored; spurious mem_rsp_valid_i in RF_REQ ignored.
- Assert rst_ni low during RF_WAIT -> no rsp_valid_o, all outputs 0; after release the same address misses again.
